// File: rtl/tlc_multi_dir.sv
// tlc_multi_dir: traffic-light controller for NUM_DIR approaches.
// One direction at a time runs GREEN -> YELLOW -> ALLRED; the next green is
// chosen round-robin over the demand flags. Adds a run/hold enable and a
// night flash mode. All outputs are registered.
module tlc_multi_dir #(
  parameter int  NUM_DIR    = 2,
  parameter int  CNT_W      = 8,
  parameter int  GREEN_CYC  = 8,
  parameter int  YELLOW_CYC = 3,
  parameter int  ALLRED_CYC = 1,
  parameter int  FLASH_CYC  = 4,
  localparam int DIR_W      = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flash_mode,
  input  logic [NUM_DIR-1:0]   demand,
  output logic [3*NUM_DIR-1:0] light,
  output logic [DIR_W-1:0]     active_dir,
  output logic [1:0]           phase
);

  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_FLASH  = 2'd3
  } phase_t;

  // Timer reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] LP_GREEN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] LP_YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] LP_ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] LP_FLASH_LD  = CNT_W'(FLASH_CYC - 1);

  localparam logic [2:0] LP_RED    = 3'b100;
  localparam logic [2:0] LP_GRN    = 3'b010;
  localparam logic [2:0] LP_YEL    = 3'b001;
  localparam logic [2:0] LP_OFF    = 3'b000;
  localparam logic [DIR_W:0] LP_NUM = (DIR_W + 1)'(NUM_DIR);

  phase_t               r_phase;
  logic [DIR_W-1:0]     r_dir;
  logic [CNT_W-1:0]     r_timer;
  logic                 r_blink;
  logic [3*NUM_DIR-1:0] r_light;

  phase_t               w_phase_next;
  logic [DIR_W-1:0]     w_dir_next;
  logic [CNT_W-1:0]     w_timer_next;
  logic                 w_blink_next;
  logic [3*NUM_DIR-1:0] w_light_next;

  logic [DIR_W-1:0]     w_cand [NUM_DIR];
  logic [NUM_DIR-1:0]   w_cand_dem;
  logic [DIR_W-1:0]     w_pick;
  logic                 w_hit;
  logic                 w_tmr_zero;

  genvar gi;

  assign w_tmr_zero = (r_timer == '0);

  // Candidate k is the direction (active+1+k) mod NUM_DIR; the last
  // candidate is the active direction itself, reached after a full wrap.
  generate
    for (gi = 0; gi < NUM_DIR; gi++) begin : g_cand
      localparam logic [DIR_W:0] LP_OFS = (DIR_W + 1)'(gi + 1);
      logic [DIR_W:0] w_sum;
      assign w_sum          = {1'b0, r_dir} + LP_OFS;
      assign w_cand[gi]     = (w_sum >= LP_NUM) ? DIR_W'(w_sum - LP_NUM) : w_sum[DIR_W-1:0];
      assign w_cand_dem[gi] = demand[w_cand[gi]];
    end
  endgenerate

  // First candidate with demand wins; with no demand at all, plain rotation.
  always_comb begin
    w_pick = w_cand[0];
    w_hit  = 1'b0;
    for (int k = 0; k < NUM_DIR; k++) begin
      if (!w_hit && w_cand_dem[k]) begin
        w_pick = w_cand[k];
        w_hit  = 1'b1;
      end
    end
  end

  // Next-state logic: flash has priority over everything, en gates the
  // normal sequence, and FLASH exits as soon as flash_mode drops.
  always_comb begin
    w_phase_next = r_phase;
    w_dir_next   = r_dir;
    w_timer_next = r_timer;
    w_blink_next = r_blink;
    if (r_phase == PH_FLASH) begin
      if (!flash_mode) begin
        w_phase_next = PH_ALLRED;
        w_timer_next = LP_ALLRED_LD;
      end else if (w_tmr_zero) begin
        w_timer_next = LP_FLASH_LD;
        w_blink_next = ~r_blink;
      end else begin
        w_timer_next = r_timer - 1'b1;
      end
    end else if (flash_mode) begin
      w_phase_next = PH_FLASH;
      w_timer_next = LP_FLASH_LD;
      w_blink_next = 1'b1;
    end else if (en) begin
      if (w_tmr_zero) begin
        case (r_phase)
          PH_ALLRED: begin
            w_phase_next = PH_GREEN;
            w_dir_next   = w_pick;
            w_timer_next = LP_GREEN_LD;
          end
          PH_GREEN: begin
            w_phase_next = PH_YELLOW;
            w_timer_next = LP_YELLOW_LD;
          end
          default: begin
            w_phase_next = PH_ALLRED;
            w_timer_next = LP_ALLRED_LD;
          end
        endcase
      end else begin
        w_timer_next = r_timer - 1'b1;
      end
    end
  end

  // Lamp code per direction derived from the next state, so the registered
  // lights change on the same edge as the phase.
  generate
    for (gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
      localparam logic [DIR_W-1:0] LP_ME = DIR_W'(gi);
      assign w_light_next[3*gi +: 3] =
          (w_phase_next == PH_FLASH)                         ? (w_blink_next ? LP_YEL : LP_OFF) :
          (w_phase_next == PH_GREEN  && w_dir_next == LP_ME) ? LP_GRN :
          (w_phase_next == PH_YELLOW && w_dir_next == LP_ME) ? LP_YEL :
                                                               LP_RED;
    end
  endgenerate

  // State and output registers; reset forces all-red immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= PH_ALLRED;
      r_dir   <= '0;
      r_timer <= LP_ALLRED_LD;
      r_blink <= 1'b1;
      r_light <= {NUM_DIR{LP_RED}};
    end else begin
      r_phase <= w_phase_next;
      r_dir   <= w_dir_next;
      r_timer <= w_timer_next;
      r_blink <= w_blink_next;
      r_light <= w_light_next;
    end
  end

  assign light      = r_light;
  assign active_dir = r_dir;
  assign phase      = r_phase;

endmodule

// File: tb/tb_tlc_multi_dir.sv
// Testbench for tlc_multi_dir (2 directions, green/yellow/allred/flash =
// 4/2/1/2 cycles). Directed steps push hand-computed expected outputs into a
// queue; a monitor pops one entry per clock and also checks the lamp
// invariants and phase durations on every cycle.
module tb_tlc_multi_dir;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       flash_mode = 1'b0;
  logic [1:0] demand = 2'b11;
  logic [5:0] light;
  logic [0:0] active_dir;
  logic [1:0] phase;

  typedef struct {
    logic [5:0] light;
    logic       dir;
    logic [1:0] ph;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  tlc_multi_dir #(
    .NUM_DIR(2), .CNT_W(8), .GREEN_CYC(4), .YELLOW_CYC(2),
    .ALLRED_CYC(1), .FLASH_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flash_mode(flash_mode),
    .demand(demand), .light(light), .active_dir(active_dir), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, expv);
    end
  endtask

  function automatic int dur_of(input logic [1:0] p);
    case (p)
      2'd0:    return 1;
      2'd1:    return 4;
      default: return 2;
    endcase
  endfunction

  // One directed clock: drive inputs, queue the expected post-edge outputs.
  task automatic step(input logic e, input logic f, input logic [1:0] d,
                      input logic [5:0] l, input logic ad, input logic [1:0] ph,
                      input string tag);
    exp_t x;
    en = e;
    flash_mode = f;
    demand = d;
    x.light = l;
    x.dir = ad;
    x.ph = ph;
    x.tag = tag;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic e, input logic f, input logic [1:0] d,
                     input logic [5:0] l, input logic ad, input logic [1:0] ph,
                     input string tag);
    for (int i = 0; i < n; i++) step(e, f, d, l, ad, ph, tag);
  endtask

  // Full period for one direction with demand d: green, yellow, allred.
  task automatic period(input logic [1:0] d, input logic ad, input string tag);
    if (ad) begin
      run(4, 1'b1, 1'b0, d, 6'b010_100, 1'b1, 2'd1, {tag, "_g"});
      run(2, 1'b1, 1'b0, d, 6'b001_100, 1'b1, 2'd2, {tag, "_y"});
      run(1, 1'b1, 1'b0, d, 6'b100_100, 1'b1, 2'd0, {tag, "_r"});
    end else begin
      run(4, 1'b1, 1'b0, d, 6'b100_010, 1'b0, 2'd1, {tag, "_g"});
      run(2, 1'b1, 1'b0, d, 6'b100_001, 1'b0, 2'd2, {tag, "_y"});
      run(1, 1'b1, 1'b0, d, 6'b100_100, 1'b0, 2'd0, {tag, "_r"});
    end
  endtask

  // Monitor: scoreboard pop, invariants and phase-duration tracking.
  logic [1:0] mon_pre_ph;
  logic       mon_pre_go;
  logic       mon_pre_rst;
  int         mon_cnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      mon_pre_ph  = phase;
      mon_pre_go  = en && !flash_mode;
      mon_pre_rst = rst;
      #1;
      if (rst || mon_pre_rst) begin
        mon_cnt = 0;
      end else begin
        int gy;
        logic has_g;
        gy = 0;
        has_g = 1'b0;
        for (int k = 0; k < 2; k++) begin
          if (light[3*k +: 3] == 3'b010 || light[3*k +: 3] == 3'b001) gy++;
          if (light[3*k +: 3] == 3'b010) has_g = 1'b1;
        end
        if (phase != 2'd3) check("inv_one_active", 32'(gy <= 1), 32'd1);
        else               check("inv_no_green_in_flash", 32'(has_g), 32'd0);
        if (phase == 2'd0) check("inv_allred_lights", 32'(light), 32'(6'b100_100));
        if (mon_pre_ph != phase) begin
          if (mon_pre_ph != 2'd3 && phase != 2'd3)
            check("phase_duration", 32'(mon_cnt + (mon_pre_go ? 1 : 0)), 32'(dur_of(mon_pre_ph)));
          mon_cnt = 0;
        end else if (mon_pre_ph != 2'd3 && mon_pre_go) begin
          mon_cnt++;
        end
      end
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn %-10s light=%b_%b dir=%0d phase=%0d", e.tag, light[5:3], light[2:0],
                 active_dir, phase);
        check({e.tag, "_light"}, 32'(light), 32'(e.light));
        check({e.tag, "_dir"},   32'(active_dir), 32'(e.dir));
        check({e.tag, "_phase"}, 32'(phase), 32'(e.ph));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset is asserted before any clock edge: outputs must follow at once.
    #1 rst = 1'b1;
    #1;
    check("reset_light", 32'(light), 32'(6'b100_100));
    check("reset_phase", 32'(phase), 32'd0);
    check("reset_dir",   32'(active_dir), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: both directions demanding, alternate dir1, dir0 (period 14).
    for (int p = 0; p < 2; p++) begin
      period(2'b11, 1'b1, "t1_d1");
      period(2'b11, 1'b0, "t1_d0");
    end

    // 2: only dir0 demands, so dir0 keeps winning.
    period(2'b01, 1'b0, "t2_d0");
    period(2'b01, 1'b0, "t2_d0");
    // No demand: plain rotation. Demand on dir1 only: dir1 repeats itself.
    period(2'b00, 1'b1, "t2_rot");
    period(2'b00, 1'b0, "t2_rot");
    period(2'b10, 1'b1, "t2_self");
    period(2'b10, 1'b1, "t2_self");
    period(2'b01, 1'b0, "t2_back");

    // 3: hold for 5 cycles after 2 green cycles; 2 green cycles remain.
    run(2, 1'b1, 1'b0, 2'b01, 6'b100_010, 1'b0, 2'd1, "t3_g_pre");
    run(5, 1'b0, 1'b0, 2'b01, 6'b100_010, 1'b0, 2'd1, "t3_hold");
    run(2, 1'b1, 1'b0, 2'b01, 6'b100_010, 1'b0, 2'd1, "t3_g_post");
    run(2, 1'b1, 1'b0, 2'b01, 6'b100_001, 1'b0, 2'd2, "t3_y");
    run(1, 1'b1, 1'b0, 2'b01, 6'b100_100, 1'b0, 2'd0, "t3_r");

    // 4: flash during yellow, blink 2 on / 2 off, exit ignores en=0.
    run(4, 1'b1, 1'b0, 2'b11, 6'b010_100, 1'b1, 2'd1, "t4_g");
    run(1, 1'b1, 1'b0, 2'b11, 6'b001_100, 1'b1, 2'd2, "t4_y");
    run(2, 1'b1, 1'b1, 2'b11, 6'b001_001, 1'b1, 2'd3, "t4_fl_on");
    run(2, 1'b1, 1'b1, 2'b11, 6'b000_000, 1'b1, 2'd3, "t4_fl_off");
    run(2, 1'b1, 1'b1, 2'b11, 6'b001_001, 1'b1, 2'd3, "t4_fl_on2");
    run(1, 1'b0, 1'b0, 2'b11, 6'b100_100, 1'b1, 2'd0, "t4_exit");
    period(2'b11, 1'b0, "t4_resume");
    // Flash preempts green even with en=0.
    run(1, 1'b1, 1'b0, 2'b11, 6'b010_100, 1'b1, 2'd1, "t4b_g");
    run(1, 1'b0, 1'b1, 2'b11, 6'b001_001, 1'b1, 2'd3, "t4b_fl");
    run(1, 1'b0, 1'b0, 2'b11, 6'b100_100, 1'b1, 2'd0, "t4b_exit");
    period(2'b11, 1'b0, "t4b_resume");

    // 5: async reset between edges during green.
    run(2, 1'b1, 1'b0, 2'b11, 6'b010_100, 1'b1, 2'd1, "t5_g");
    #2 rst = 1'b1;
    #1;
    check("t5_async_light", 32'(light), 32'(6'b100_100));
    check("t5_async_phase", 32'(phase), 32'd0);
    check("t5_async_dir",   32'(active_dir), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    period(2'b01, 1'b0, "t5_after");

    // 6: random inputs; only the monitor's invariants apply.
    for (int i = 0; i < 10000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) flash_mode = ~flash_mode;
      demand = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    flash_mode = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tlc_multi_dir.md
Name: tlc_multi_dir

Overview:
- Parametrised traffic-light controller driving NUM_DIR approach directions.
- Only one direction is ever green. Each green is followed by yellow, then an all-red clearance interval.
- Adds demand-based skipping, a run/hold enable, and a night flash mode that the single-approach three-state controller does not have.
- Sits at the top of the intersection subsystem and drives the lamp drivers directly.

Parameters:
- NUM_DIR, 2, number of approach directions (2..8).
- CNT_W, 8, phase timer width.
- GREEN_CYC, 8, green duration in clk cycles (1..2^CNT_W-1).
- YELLOW_CYC, 3, yellow duration in clk cycles (1..2^CNT_W-1).
- ALLRED_CYC, 1, all-red clearance in clk cycles (1..2^CNT_W-1).
- FLASH_CYC, 4, half-period of the flash blink in clk cycles (1..2^CNT_W-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  1 = sequence runs; 0 = state, timer and lights hold.
- flash_mode  input  1  1 = night flash mode.
- demand  input  NUM_DIR  per-direction vehicle-present flags, sampled at ALLRED exit.
- light  output  3*NUM_DIR  per-direction lamp code; direction d occupies bits [3d+2:3d] = {R,G,Y}.
  - RED = 3'b100, GREEN = 3'b010, YELLOW = 3'b001, OFF = 3'b000.
- active_dir  output  $clog2(NUM_DIR) (min 1)  direction currently owning green/yellow.
- phase  output  2  state code: 0 ALLRED, 1 GREEN, 2 YELLOW, 3 FLASH.

Behaviour:
- Reset (async assert, released synchronously by the integrator):
  - phase = ALLRED, active_dir = 0, timer = ALLRED_CYC-1, blink = 1.
  - All light fields = RED.
- All outputs are registered. light, active_dir and phase change on the same clk edge as the state.
- Timer: loaded with (duration-1) on phase entry; decrements each enabled cycle; phase exits on the edge where timer == 0. Each phase therefore lasts exactly its duration in cycles.
- Transitions when en=1 and flash_mode=0:
  - ALLRED -> GREEN: active_dir <= next direction (see selection below), timer <= GREEN_CYC-1.
  - GREEN -> YELLOW: timer <= YELLOW_CYC-1; active_dir unchanged.
  - YELLOW -> ALLRED: timer <= ALLRED_CYC-1.
  - FLASH -> ALLRED: occurs on the first edge after flash_mode falls (en ignored). timer <= ALLRED_CYC-1, active_dir unchanged, so selection resumes from the pre-flash direction.
- Next-direction selection: round-robin search from active_dir+1 with wrap (NUM_DIR-1 -> 0), over demand sampled at the exit edge.
  - First direction with demand=1 wins; this may be active_dir itself after a full wrap.
  - If demand == 0, the winner is active_dir+1 (plain rotation).
- Lights:
  - GREEN: active_dir field = GREEN, all others RED.
  - YELLOW: active_dir field = YELLOW, all others RED.
  - ALLRED: all fields RED.
  - FLASH: all fields YELLOW when blink=1, OFF when blink=0. blink toggles every FLASH_CYC cycles and reloads to 1 on FLASH entry.
- flash_mode=1 in any non-FLASH state: enter FLASH on the next edge, regardless of en and timer (even mid-green). Timer reloads to FLASH_CYC-1.
- en=0 and flash_mode=0: everything frozen, including the timer. Resuming with en=1 continues with the remaining count.
- Simultaneous flash_mode=1 with a timer expiry: FLASH wins.
- Invariants (must hold in every cycle):
  - At most one field is GREEN or YELLOW outside FLASH.
  - No field is ever GREEN in FLASH.
  - Every GREEN is followed by exactly YELLOW_CYC cycles of YELLOW, then ALLRED_CYC cycles of ALLRED, except when flash preempts.
- Reset asserted mid-phase: outputs return to reset values immediately, with no wait for clk.

Test Plan:
(All with NUM_DIR=2, GREEN_CYC=4, YELLOW_CYC=2, ALLRED_CYC=1, FLASH_CYC=2, en=1.)
1. Reset, then demand=2'b11 -> 1 cycle light=100_100; dir1 green 4 cycles (light=010_100); 2 cycles 001_100; 1 cycle 100_100; dir0 green 010 in bits[2:0]; repeats with period 14.
2. demand=2'b01 held -> dir0 is the only direction ever green; each GREEN/YELLOW/ALLRED = 4/2/1 cycles; active_dir stays 0.
3. Mid-green (cycle 2 of 4), en=0 for 5 cycles, then en=1 -> light frozen during hold; green lasts exactly 2 more cycles, then yellow.
4. flash_mode=1 during YELLOW -> next edge phase=3, light=001_001 for 2 cycles, 000_000 for 2 cycles, alternating. Drop flash_mode -> next edge light=100_100 for 1 cycle, then green resumes from active_dir+1.
5. rst pulsed asynchronously mid-green (between clk edges) -> light=100_100, phase=0, active_dir=0 before the next edge.
6. Random demand/en/flash_mode for 10k cycles -> invariant assertions never fire.
